// File: rtl/alu_concat_packer.sv
// Streaming operand packer: gathers NUM operands of IN_W bits into one
// NUM*IN_W result word, with partial-word flush and a per-word operand count.
module alu_concat_packer #(
  parameter int IN_W      = 4,
  parameter int NUM       = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [NUM*IN_W-1:0]          out_data,
  output logic [$clog2(NUM+1)-1:0]     out_cnt,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int CW = $clog2(NUM+1);
  localparam int DW = NUM * IN_W;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on internal state and out_ready, never on in_valid;
  // out_valid is registered and held until out_ready is seen.

  logic [DW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_flush_pend;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] r_out_cnt;
  logic          r_out_valid;

  logic          w_out_free;
  logic          w_last;
  logic          w_accept;
  logic          w_complete;
  logic          w_service;
  logic          w_flush_set;
  logic [DW-1:0] w_acc_fill;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_last     = (r_cnt == CW'(NUM - 1));
  // A pending flush freezes the partial word so nothing joins it.
  assign in_ready   = !r_flush_pend && (!w_last || w_out_free);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && w_last;
  assign w_service  = r_flush_pend && w_out_free && !w_accept;
  // A flush alongside a completing operand is moot: the word goes out full.
  assign w_flush_set = flush && !w_complete && ((r_cnt != '0) || w_accept);

  for (genvar k = 0; k < NUM; k++) begin : g_slot
    localparam int LO = (LSB_FIRST != 1'b0) ? k * IN_W : (NUM - 1 - k) * IN_W;
    assign w_acc_fill[LO +: IN_W] = (r_cnt == CW'(k)) ? in_data : r_acc[LO +: IN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_out_data   <= '0;
      r_out_cnt    <= '0;
      r_out_valid  <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_acc_fill;
      r_out_cnt   <= CW'(NUM);
      r_out_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else if (w_service) begin
      r_out_data   <= r_acc;
      r_out_cnt    <= r_cnt;
      r_out_valid  <= 1'b1;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_fill;
        r_cnt <= r_cnt + CW'(1);
      end
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_flush_set) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_concat_packer.sv
// Directed bench for alu_concat_packer: two NUM=2 instances (both packing
// orders) share one stimulus stream, a NUM=4 instance gets its own.
module tb_alu_concat_packer;

  logic clk;
  logic rst_n;

  // NUM=2 instances (a: MSB-first, b: LSB-first) share inputs
  logic [3:0]  a_data;
  logic        a_valid;
  logic        a_flush;
  logic        a_ready;
  logic        a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_cnt;
  logic        a_out_valid;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_cnt;
  logic        b_out_valid;

  // NUM=4 instance
  logic [3:0]  c_data;
  logic        c_valid;
  logic        c_flush;
  logic        c_ready;
  logic        c_in_ready;
  logic [15:0] c_out_data;
  logic [2:0]  c_out_cnt;
  logic        c_out_valid;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  alu_concat_packer #(.IN_W(4), .NUM(2), .LSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_in_ready),
    .flush(a_flush),
    .out_data(a_out_data), .out_cnt(a_out_cnt), .out_valid(a_out_valid),
    .out_ready(a_ready)
  );

  alu_concat_packer #(.IN_W(4), .NUM(2), .LSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(b_in_ready),
    .flush(a_flush),
    .out_data(b_out_data), .out_cnt(b_out_cnt), .out_valid(b_out_valid),
    .out_ready(a_ready)
  );

  alu_concat_packer #(.IN_W(4), .NUM(4), .LSB_FIRST(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_data(c_data), .in_valid(c_valid), .in_ready(c_in_ready),
    .flush(c_flush),
    .out_data(c_out_data), .out_cnt(c_out_cnt), .out_valid(c_out_valid),
    .out_ready(c_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] d, input logic v, input logic f);
    a_data  = d;
    a_valid = v;
    a_flush = f;
  endtask

  task automatic drive_c(input logic [3:0] d, input logic v, input logic f);
    c_data  = d;
    c_valid = v;
    c_flush = f;
  endtask

  // scoreboard: every word drained from instance a must match the queue head
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(a_out_data), 32'hFFFF_FFFF);
      else check("sb_word", 32'(a_out_data), exp_q.pop_front());
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    drive_a(4'h0, 1'b0, 1'b0);
    drive_c(4'h0, 1'b0, 1'b0);
    a_ready = 1'b1;
    c_ready = 1'b1;
    #1;
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_data",  32'(a_out_data),  0);
    check("rst_a_cnt",   32'(a_out_cnt),   0);
    check("rst_c_valid", 32'(c_out_valid), 0);
    check("rst_c_data",  32'(c_out_data),  0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // basic pack, both orders
    exp_q.push_back(32'hA5);
    drive_a(4'hA, 1'b1, 1'b0);
    #1 check("basic_in_ready", 32'(a_in_ready), 1);
    tick();
    check("basic_no_early_valid", 32'(a_out_valid), 0);
    drive_a(4'h5, 1'b1, 1'b0);
    tick();
    check("basic_valid", 32'(a_out_valid), 1);
    check("basic_msb_data", 32'(a_out_data), 32'hA5);
    check("basic_cnt", 32'(a_out_cnt), 2);
    check("basic_lsb_data", 32'(b_out_data), 32'h5A);
    check("basic_lsb_cnt", 32'(b_out_cnt), 2);
    drive_a(4'h0, 1'b0, 1'b0);
    tick();
    check("basic_one_cycle", 32'(a_out_valid), 0);
    check("basic_data_kept", 32'(a_out_data), 32'hA5);

    // NUM=4 partial flush then full word
    drive_c(4'h1, 1'b1, 1'b0); tick();
    drive_c(4'h2, 1'b1, 1'b0); tick();
    drive_c(4'h3, 1'b1, 1'b0); tick();
    drive_c(4'h0, 1'b0, 1'b1); tick();
    drive_c(4'h0, 1'b0, 1'b0);
    check("c_pend_in_ready", 32'(c_in_ready), 0);
    check("c_pend_no_valid", 32'(c_out_valid), 0);
    tick();
    check("c_flush_valid", 32'(c_out_valid), 1);
    check("c_flush_data", 32'(c_out_data), 32'h1230);
    check("c_flush_cnt", 32'(c_out_cnt), 3);
    drive_c(4'h4, 1'b1, 1'b0); tick();
    drive_c(4'h5, 1'b1, 1'b0); tick();
    drive_c(4'h6, 1'b1, 1'b0); tick();
    drive_c(4'h7, 1'b1, 1'b0); tick();
    check("c_full_valid", 32'(c_out_valid), 1);
    check("c_full_data", 32'(c_out_data), 32'h4567);
    check("c_full_cnt", 32'(c_out_cnt), 4);
    drive_c(4'h0, 1'b0, 1'b0);
    tick();
    check("c_clear_valid", 32'(c_out_valid), 0);
    check("c_clear_data_kept", 32'(c_out_data), 32'h4567);

    // backpressure on NUM=2
    exp_q.push_back(32'h12);
    exp_q.push_back(32'h34);
    a_ready = 1'b0;
    drive_a(4'h1, 1'b1, 1'b0); tick();
    drive_a(4'h2, 1'b1, 1'b0); tick();
    check("bp_first_word", 32'(a_out_data), 32'h12);
    drive_a(4'h3, 1'b1, 1'b0); tick();
    drive_a(4'h4, 1'b1, 1'b0);
    #1 check("bp_in_ready_low", 32'(a_in_ready), 0);
    tick();
    check("bp_hold_data", 32'(a_out_data), 32'h12);
    check("bp_hold_valid", 32'(a_out_valid), 1);
    a_ready = 1'b1;
    #1 check("bp_in_ready_comb", 32'(a_in_ready), 1);
    tick();
    check("bp_second_word", 32'(a_out_data), 32'h34);
    check("bp_second_valid", 32'(a_out_valid), 1);
    drive_a(4'h0, 1'b0, 1'b0);
    tick();
    check("bp_drained", 32'(a_out_valid), 0);

    // flush with nothing buffered
    drive_a(4'h0, 1'b0, 1'b1); tick();
    drive_a(4'h0, 1'b0, 1'b0);
    check("empty_flush_a", 32'(a_out_valid), 0);
    tick();
    check("empty_flush_b", 32'(a_out_valid), 0);

    // flush together with the completing operand
    exp_q.push_back(32'h67);
    drive_a(4'h6, 1'b1, 1'b0); tick();
    drive_a(4'h7, 1'b1, 1'b1); tick();
    check("cflush_data", 32'(a_out_data), 32'h67);
    check("cflush_cnt", 32'(a_out_cnt), 2);
    drive_a(4'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("cflush_no_extra", 32'(a_out_valid), 0);

    // flush while output held
    exp_q.push_back(32'h89);
    exp_q.push_back(32'hB0);
    a_ready = 1'b0;
    drive_a(4'h8, 1'b1, 1'b0); tick();
    drive_a(4'h9, 1'b1, 1'b0); tick();
    drive_a(4'hB, 1'b1, 1'b0); tick();
    drive_a(4'h0, 1'b0, 1'b1); tick();
    drive_a(4'h0, 1'b0, 1'b0);
    check("hflush_in_ready", 32'(a_in_ready), 0);
    tick();
    check("hflush_hold_data", 32'(a_out_data), 32'h89);
    a_ready = 1'b1;
    drive_a(4'hE, 1'b1, 1'b0);
    #1 check("hflush_in_ready_blk", 32'(a_in_ready), 0);
    tick();
    drive_a(4'h0, 1'b0, 1'b0);
    check("hflush_data", 32'(a_out_data), 32'hB0);
    check("hflush_cnt", 32'(a_out_cnt), 1);
    check("hflush_valid", 32'(a_out_valid), 1);
    tick();
    check("hflush_drained", 32'(a_out_valid), 0);
    check("hflush_ready_back", 32'(a_in_ready), 1);

    // asynchronous reset mid-word with a held output
    a_ready = 1'b0;
    drive_a(4'h1, 1'b1, 1'b0); tick();
    drive_a(4'h2, 1'b1, 1'b0); tick();
    drive_a(4'h3, 1'b1, 1'b0); tick();
    drive_a(4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_out_valid), 0);
    check("arst_data", 32'(a_out_data), 0);
    check("arst_cnt", 32'(a_out_cnt), 0);
    a_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(32'hCD);
    drive_a(4'hC, 1'b1, 1'b0); tick();
    drive_a(4'hD, 1'b1, 1'b0); tick();
    check("post_rst_data", 32'(a_out_data), 32'hCD);
    check("post_rst_cnt", 32'(a_out_cnt), 2);
    drive_a(4'h0, 1'b0, 1'b0);
    tick();
    tick();

    check("sb_all_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_concat_packer.md
Name: alu_concat_packer

Overview:
- Streaming concatenation unit: packs NUM consecutive IN_W-bit operands into one NUM*IN_W-bit result word.
- It is the sequential, parametrised successor to the fixed 4+4→8 combinational concatenate in the simple ALU path.
- Sits between the operand source and the result bus, with valid/ready handshakes on both sides.
- Adds partial-word flush, selectable packing order and a per-word valid count.

Parameters:
- IN_W, 4, width of one input operand (≥1).
- NUM, 2, operands per output word (≥2).
- LSB_FIRST, 0, packing order. 0: first operand lands in the MSBs, so with NUM=2 the result is {first,second}. 1: first operand lands in bits [IN_W-1:0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  IN_W  operand.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- flush  input  1  single-cycle request to emit the current partial word.
- out_data  output  NUM*IN_W  packed result.
- out_cnt  output  clog2(NUM+1)  number of valid operands in out_data (1..NUM).
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, flush_pend=0, out_data=0, out_cnt=0, out_valid=0.
- State: accumulator acc (NUM*IN_W), fill counter cnt (0..NUM-1), flush_pend flag, registered output stage.
- Accept (in_valid && in_ready): the operand is written into slot cnt.
  - Slot k occupies bits [(NUM-1-k)*IN_W +: IN_W] when LSB_FIRST=0.
  - Slot k occupies bits [k*IN_W +: IN_W] when LSB_FIRST=1.
- Output stage is free when out_valid==0 || out_ready==1 (drain this cycle).
- in_ready = (cnt != NUM-1) || out_free. Combinational from out_ready is permitted; there is no path from in_valid to in_ready.
- Complete: accept with cnt==NUM-1 takes effect in the same edge:
  - out_data ← acc with the final slot filled; out_cnt ← NUM; out_valid ← 1.
  - acc ← 0; cnt ← 0.
  - Latency is one cycle from the final accept to out_valid.
- Non-completing accept: cnt ← cnt+1. Empty slots of acc always hold 0.
- Flush:
  - flush=1 sets flush_pend if cnt>0, or if an accept happens in the same cycle with cnt+1 < NUM.
  - flush with nothing buffered is ignored.
  - A flush in the same cycle as a completing accept is ignored (the word is emitted full).
  - Service: flush_pend && out_free && !(in_valid && in_ready) in a given cycle.
    - out_data ← acc (unfilled slots zero); out_cnt ← cnt; out_valid ← 1.
    - acc ← 0; cnt ← 0; flush_pend ← 0.
  - While flush_pend=1, in_ready=0, so no new operands join the flushed word.
- Output hold: while out_valid && !out_ready, out_data and out_cnt stay stable and out_valid stays 1.
- Output clear: on out_ready with no new word loading, out_valid ← 0. out_data and out_cnt keep their last values.
- Back-to-back: with out_ready held at 1, one full word every NUM accepted cycles. No bubble at wrap: cnt NUM-1 → 0.
- Reset mid-operation: the partial word, pending flush and held output are discarded; the first post-reset operand goes to slot 0.
- Widths: no arithmetic on data; cnt wraps only via the complete path. out_cnt encodes NUM exactly.

Test Plan:
- IN_W=4, NUM=2, LSB_FIRST=0, out_ready=1; send 0xA then 0x5 → out_data=0xA5, out_cnt=2, out_valid=1 for exactly one cycle, one cycle after the 0x5 accept.
- Same config with LSB_FIRST=1; send 0xA, 0x5 → out_data=0x5A, out_cnt=2.
- IN_W=4, NUM=4; send 0x1, 0x2, 0x3 then pulse flush → out_data=0x1230, out_cnt=3. The next stream 0x4, 0x5, 0x6, 0x7 → 0x4567, out_cnt=4.
- Backpressure, NUM=2: first word 0x12 held with out_ready=0. Send 0x3, then 0x4 is offered → in_ready=0 while cnt=1. out_data stays 0x12. Raise out_ready → 0x34 loads in the same edge 0x12 drains; no loss or duplication.
- Corner cases:
  - flush with cnt=0 → no output.
  - flush in the same cycle as the completing operand → a single word, out_cnt=NUM.
  - flush while the output is held → flush_pend=1 and in_ready=0 until the drain, then the partial word is emitted.
- Assert rst_n low mid-word (cnt=1) and while out_valid=1 → all outputs 0 immediately (asynchronous). After release, 0xC, 0xD → 0xCD.
